inst_sram_responder: RTL and testbench
======================================

# inst_sram_responder

Responder end of the instruction-fetch SRAM interface. It holds the instruction memory array and answers every fetch request driven by the IF stage with read data exactly one cycle later, so the IF stage never sees a wait state. A side loader port with a valid/ready handshake fills or patches the array, always yielding to fetch traffic. Sits between the CPU core's `inst_sram_*` pins and the SoC, replacing an external block RAM.

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: array holds 2^DEPTH_LOG2 32-bit words (default 16 KiB).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `inst_sram_en` input 1: fetch request this cycle.
- `inst_sram_we` input 4: byte write enables; 4'b0000 means read.
- `inst_sram_addr` input 32: byte address; bits [1:0] ignored.
- `inst_sram_wdata` input 32: write data.
- `inst_sram_rdata` output 32: read data, registered.
- `ld_valid` input 1: loader word write request.
- `ld_ready` output 1: loader request can be accepted this cycle.
- `ld_addr` input 32: loader byte address; bits [1:0] ignored.
- `ld_data` input 32: loader write word (all four bytes written).
- `ld_count` output 16: number of accepted loader writes, saturating.
- `oor_err` output 1: sticky out-of-range flag.

## Operation
- Word index: `off = addr - BASE_ADDR` in 32-bit modulo arithmetic; `idx = off[DEPTH_LOG2+1:2]`; the access is in range when `off < (4 << DEPTH_LOG2)`.
- Fetch read (`en=1`, `we=0`): `rdata` takes `mem[idx]` at the next edge.
- Fetch write (`en=1`, `we!=0`): each byte lane i with `we[i]=1` is written from `wdata[8i+7:8i]`. The access is read-first: `rdata` takes the pre-write word.
- Idle (`en=0`): `rdata` holds its last value. A stalled IF stage therefore keeps the instruction it fetched.
- Loader: `ld_ready = ~inst_sram_en`, combinational. A transfer occurs when `ld_valid && ld_ready`, and then `mem[idx(ld_addr)] <= ld_data`.
  - `ld_count` increments by 1 per transfer and saturates at 16'hFFFF.
  - `ld_valid` held with `ld_ready=0` is a stall. The loader must keep its address and data stable until the transfer occurs.
- Arbitration: fetch always wins, so no loader write and no fetch can occur in the same cycle.
- Array contents are not reset.
- Reset values: `inst_sram_rdata=0`, `ld_count=0`, `oor_err=0`. `ld_ready` follows `en` combinationally.
- Reset asserted mid-operation: the registers clear immediately (asynchronous). A write in the same cycle as the reset assertion has an undefined effect on the array; the bench must not rely on it.

## Timing
- Fetch read latency: 1 cycle. Request at edge N is sampled there; `rdata` is valid after edge N and stays valid until the next enabled fetch.
- Back-to-back fetches: one per cycle, no bubbles.
- Loader write: committed at the accepting edge and visible to a fetch issued on the following cycle.
- Fetch write then fetch read of the same word on consecutive cycles: the read returns the new data.
- `ld_count` and `oor_err` update at the edge of the triggering access.

## Configuration
- Macro `IRAM_OOR_CHECK_EN`, defined:
  - Out-of-range fetch reads return 32'h0340_0000 (LoongArch NOP) and set `oor_err`.
  - Out-of-range writes, fetch or loader, are dropped and set `oor_err`.
  - Out-of-range loader transfers still count in `ld_count`.
  - `oor_err` clears only on reset.
- Macro not defined:
  - No range check; `idx` wraps modulo the depth, so upper offset bits are ignored.
  - `oor_err` is tied to 0.

## Test plan
- Reset then fetch: after reset `rdata=0` and `ld_count=0`. Load word 0x02800421 at address 0x0, then fetch 0x0 → `rdata=0x02800421` one cycle later.
- Hold: fetch address 0x4 (holds 0x12345678), then drop `en` for 3 cycles → `rdata` stays 0x12345678 throughout.
- Byte write: word 0x8 holds 0xAABBCCDD; fetch write with `we=4'b0101`, `wdata=0x11223344` → that cycle's `rdata=0xAABBCCDD`; next read of 0x8 → 0xAA22CC44.
- Arbitration: `ld_valid=1` while `en=1` for 4 cycles → `ld_ready=0` and no write. `en` drops → the transfer completes in that cycle and `ld_count` goes 0→1.
- Saturation: 65537 loader transfers → `ld_count=16'hFFFF`.
- Range, with `DEPTH_LOG2=12`, `BASE_ADDR=0`, fetch of 0x4000:
  - Macro defined → `rdata=0x03400000` and `oor_err=1`.
  - Macro undefined → `rdata=mem[0]` and `oor_err=0`.

Source files
------------

// File: rtl/inst_sram_responder.sv
// inst_sram_responder
// Instruction SRAM responder: answers every IF-stage fetch with registered
// read data one cycle later, and accepts side-loader word writes whenever
// the fetch port is idle.
//
// Optional feature: define IRAM_OOR_CHECK_EN to enable address range
// checking (out-of-range fetch reads return a NOP, out-of-range writes are
// dropped, and the sticky oor_err flag is raised).
//
// Loader handshake: ld_ready is combinationally ~inst_sram_en. A transfer
// happens on a rising edge where ld_valid && ld_ready; a loader that sees
// ld_ready low must hold ld_valid, ld_addr and ld_data stable until then.
module inst_sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [15:0] ld_count,
    output logic        oor_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Instruction memory; contents are deliberately not reset.
    logic [31:0] mem [DEPTH];

    // Offsets relative to the base of the array (32-bit modulo arithmetic).
    logic [31:0]           f_off;
    logic [31:0]           l_off;
    logic [DEPTH_LOG2-1:0] f_idx;
    logic [DEPTH_LOG2-1:0] l_idx;

    assign f_off = inst_sram_addr - BASE_ADDR;
    assign l_off = ld_addr - BASE_ADDR;
    assign f_idx = f_off[DEPTH_LOG2+1:2];
    assign l_idx = l_off[DEPTH_LOG2+1:2];

    // Fetch always wins: the loader is only offered the idle fetch cycles.
    logic ld_fire;
    assign ld_ready = ~inst_sram_en;
    assign ld_fire  = ld_valid & ld_ready;

    // Qualified write strobes and the word returned to the IF stage.
    logic        f_wr_ok;
    logic        l_wr_ok;
    logic [31:0] f_rd_word;

`ifdef IRAM_OOR_CHECK_EN
    localparam logic [31:0] LOONGARCH_NOP = 32'h0340_0000;

    logic f_in_range;
    logic l_in_range;

    // 33-bit compare keeps the array size representable for any depth.
    assign f_in_range = ({1'b0, f_off} < (33'd4 << DEPTH_LOG2));
    assign l_in_range = ({1'b0, l_off} < (33'd4 << DEPTH_LOG2));
    assign f_wr_ok    = inst_sram_en & (|inst_sram_we) & f_in_range;
    assign l_wr_ok    = ld_fire & l_in_range;
    assign f_rd_word  = f_in_range ? mem[f_idx] : LOONGARCH_NOP;

    logic oor_q;

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oor_q <= 1'b0;
        end else if ((inst_sram_en && !f_in_range) || (ld_fire && !l_in_range)) begin
            oor_q <= 1'b1;
        end
    end

    assign oor_err = oor_q;
`else
    // Without range checking the index simply wraps modulo the depth.
    assign f_wr_ok   = inst_sram_en & (|inst_sram_we);
    assign l_wr_ok   = ld_fire;
    assign f_rd_word = mem[f_idx];
    assign oor_err   = 1'b0;
`endif

    // Array writes: fetch byte-lane writes, otherwise a full-word loader write.
    always_ff @(posedge clk) begin
        if (f_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_we[i]) begin
                    mem[f_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end else if (l_wr_ok) begin
            mem[l_idx] <= ld_data;
        end
    end

    // Read-first data register; holds its value while the fetch port idles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= 32'h0;
        end else if (inst_sram_en) begin
            inst_sram_rdata <= f_rd_word;
        end
    end

    // Saturating count of accepted loader transfers (in range or not).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_count <= 16'h0;
        end else if (ld_fire && (ld_count != 16'hFFFF)) begin
            ld_count <= ld_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder
// Self-checking bench for inst_sram_responder: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// word-array model. Honours IRAM_OOR_CHECK_EN the same way as the design.
module tb_inst_sram_responder;

    localparam int          DEPTH_LOG2 = 12;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0340_0000;
`ifdef IRAM_OOR_CHECK_EN
    localparam bit OOR_MODE = 1'b1;
`else
    localparam bit OOR_MODE = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [15:0] ld_count;
    logic        oor_err;

    int n_checks = 0;
    int n_errors = 0;

    inst_sram_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_count       (ld_count),
        .oor_err        (oor_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] exp_rdata;
    bit          exp_known;
    int          exp_count;
    bit          exp_oor;

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return int'((off / 4) % DEPTH);
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (64'(off) < 64'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Model: what each edge must do, from the interface rules alone.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_rdata <= 32'h0;
            exp_known <= 1'b1;
            exp_count <= 0;
            exp_oor   <= 1'b0;
        end else if (inst_sram_en) begin
            if (OOR_MODE && !in_range(inst_sram_addr)) begin
                exp_rdata <= NOP;
                exp_known <= 1'b1;
                exp_oor   <= 1'b1;
            end else begin
                exp_rdata <= m_mem[word_of(inst_sram_addr)];
                exp_known <= m_known[word_of(inst_sram_addr)];
                if (inst_sram_we != 4'h0) begin
                    m_mem[word_of(inst_sram_addr)] <=
                        merge(m_mem[word_of(inst_sram_addr)], inst_sram_we, inst_sram_wdata);
                    m_known[word_of(inst_sram_addr)] <=
                        m_known[word_of(inst_sram_addr)] || (inst_sram_we == 4'hF);
                end
            end
        end else if (ld_valid) begin
            exp_count <= (exp_count < 65535) ? exp_count + 1 : 65535;
            if (OOR_MODE && !in_range(ld_addr)) begin
                exp_oor <= 1'b1;
            end else begin
                m_mem[word_of(ld_addr)]   <= ld_data;
                m_known[word_of(ld_addr)] <= 1'b1;
            end
        end
    end

    // Compare process: every cycle out of reset, on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            check("ld_ready", {31'h0, ld_ready}, {31'h0, ~inst_sram_en});
            check("ld_count", {16'h0, ld_count}, 32'(exp_count));
            check("oor_err", {31'h0, oor_err}, {31'h0, exp_oor});
            if (exp_known) check("rdata", inst_sram_rdata, exp_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic lv, input logic [31:0] la,
                         input logic [31:0] ldd);
        @(posedge clk);
        #1;
        inst_sram_en    = en;
        inst_sram_we    = we;
        inst_sram_addr  = addr;
        inst_sram_wdata = wd;
        ld_valid        = lv;
        ld_addr         = la;
        ld_data         = ldd;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a, d);
    endtask

    task automatic fetch(input logic [31:0] a);
        drive(1'b1, 4'h0, a, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    logic        r_en;
    logic        r_lv;
    logic [31:0] r_la;
    logic [31:0] r_ld;
    logic [31:0] r_addr;
    logic [3:0]  r_we;

    initial begin
        resetn          = 1'b0;
        inst_sram_en    = 1'b0;
        inst_sram_we    = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        ld_valid        = 1'b0;
        ld_addr         = 32'h0;
        ld_data         = 32'h0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset values.
        @(negedge clk);
        check("reset_rdata", inst_sram_rdata, 32'h0);
        check("reset_ld_count", {16'h0, ld_count}, 32'h0);

        // Load then fetch word 0.
        load(32'h0, 32'h0280_0421);
        fetch(32'h0);
        idle();
        @(negedge clk);
        check("fetch_word0", inst_sram_rdata, 32'h0280_0421);

        // Hold while the fetch port idles for 3 cycles.
        load(32'h4, 32'h1234_5678);
        fetch(32'h4);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_rdata", inst_sram_rdata, 32'h1234_5678);
        end

        // Byte-lane write, read-first.
        load(32'h8, 32'hAABB_CCDD);
        drive(1'b1, 4'b0101, 32'h8, 32'h1122_3344, 1'b0, 32'h0, 32'h0);
        fetch(32'h8);
        @(negedge clk);
        check("bytewr_old", inst_sram_rdata, 32'hAABB_CCDD);
        idle();
        @(negedge clk);
        check("bytewr_new", inst_sram_rdata, 32'hAA22_CC44);

        // Arbitration: loader stalled by 4 fetch cycles, then completes.
        drive(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 32'hC, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            check("arb_ready_low", {31'h0, ld_ready}, 32'h0);
            check("arb_count_held", {16'h0, ld_count}, 32'd3);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hC, 32'hDEAD_BEEF);
        @(negedge clk);
        check("arb_ready_high", {31'h0, ld_ready}, 32'h1);
        idle();
        @(negedge clk);
        check("arb_count_inc", {16'h0, ld_count}, 32'd4);
        fetch(32'hC);
        idle();
        @(negedge clk);
        check("arb_data", inst_sram_rdata, 32'hDEAD_BEEF);

        // Range: fetch just past the end of the array.
        fetch(32'h4000);
        idle();
        @(negedge clk);
        if (OOR_MODE) begin
            check("oor_rdata", inst_sram_rdata, NOP);
            check("oor_flag", {31'h0, oor_err}, 32'h1);
        end else begin
            check("wrap_rdata", inst_sram_rdata, 32'h0280_0421);
            check("wrap_flag", {31'h0, oor_err}, 32'h0);
        end

        // Preload a small window so random reads hit known words.
        for (int i = 0; i < 64; i++) load(32'(i * 4), $urandom);

        // Randomized traffic; a stalled loader keeps its request stable.
        r_en = 1'b0;
        r_lv = 1'b0;
        r_la = 32'h0;
        r_ld = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            if (!(r_lv && r_en)) begin
                r_lv = ($urandom_range(0, 1) == 1);
                r_la = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 63) * 4)
                                                   : 32'($urandom_range(0, 255));
                r_ld = $urandom;
            end
            r_en   = ($urandom_range(0, 1) == 1);
            r_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            r_addr = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 63) * 4)
                                                 : 32'($urandom_range(0, 255));
            drive(r_en, r_we, r_addr, $urandom, r_lv, r_la, r_ld);
        end

        // Saturation: 65537 back-to-back loader transfers.
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h100, 32'h0BAD_F00D);
        repeat (65537) @(posedge clk);
        idle();
        @(negedge clk);
        check("sat_count", {16'h0, ld_count}, 32'h0000_FFFF);

        // Asynchronous reset mid-cycle clears the registers at once.
        #1 resetn = 1'b0;
        #1;
        check("async_rst_rdata", inst_sram_rdata, 32'h0);
        check("async_rst_count", {16'h0, ld_count}, 32'h0);
        check("async_rst_oor", {31'h0, oor_err}, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        fetch(32'h100);
        idle();
        @(negedge clk);
        check("after_rst_fetch", inst_sram_rdata, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
